if_fetch_stage: RTL

Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues requests to instruction memory over a grant/response handshake. Returned words are buffered in a 2-entry queue, and each instruction is presented to IF/ID as {pc, pcAdd4, inst} together with a bubble/flush control. It honours the hazard unit's stall and EX-stage redirects, discarding any in-flight wrong-path fetch.

---
 rtl/riscv_pipe_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/if_fetch_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RV32I fetch front end.
package riscv_pipe_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INST_BUBBLE  = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    // REQ: may issue a fetch; WAIT: one fetch in flight;
    // DROP: the in-flight fetch was killed by a redirect and its word is discarded.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_add4;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry queue of fetched instructions; clear has priority over push.
module fetch_fifo
    import riscv_pipe_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t push_data,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    // A push on a full queue is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (clear) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;
    assign head  = empty ? '{pc: '0, pc_add4: '0, inst: INST_BUBBLE} : mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, talks to imem, feeds IF/ID.
module if_fetch_stage #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = riscv_pipe_pkg::RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirectPc,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemGnt,
    input  logic            imemRvalid,
    input  logic [XLEN-1:0] imemRdata,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcAdd4,
    output logic [XLEN-1:0] inst,
    output logic            instValid,
    output logic            flushOut
);

    riscv_pipe_pkg::fetch_state_e state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;

    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [1:0] fifo_count;
    logic [2:0] occupancy;
    logic       can_issue;
    logic       granted;
    riscv_pipe_pkg::fetch_entry_t push_entry;
    riscv_pipe_pkg::fetch_entry_t head;

    assign pop  = instValid & ~stall & ~redirect;
    assign push = (state_q == riscv_pipe_pkg::WAIT) & imemRvalid & ~redirect;

    // Credit counts the in-flight word as already queued and lets a departing
    // head free its slot early so a 1-cycle memory sustains one fetch per cycle.
    // Redirect does not withdraw that credit: the queue is cleared anyway.
    assign occupancy = {1'b0, fifo_count}
                     + {2'b00, state_q == riscv_pipe_pkg::WAIT}
                     - {2'b00, instValid & ~stall};

    // A returning (non-killed) response frees the port for a back-to-back request.
    assign can_issue = (state_q == riscv_pipe_pkg::REQ)
                     | ((state_q != riscv_pipe_pkg::REQ) & imemRvalid & ~redirect);

    assign imemReq  = ~reset & can_issue & (occupancy < 3'd2);
    assign imemAddr = fetch_pc_q;
    assign granted  = imemReq & imemGnt;

    // Request FSM next state and fetch/request address bookkeeping.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        if (granted) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            req_addr_d = fetch_pc_q;
        end
        case (state_q)
            riscv_pipe_pkg::REQ: begin
                if (granted) begin
                    state_d = redirect ? riscv_pipe_pkg::DROP : riscv_pipe_pkg::WAIT;
                end
            end
            riscv_pipe_pkg::WAIT: begin
                if (imemRvalid) begin
                    state_d = granted ? riscv_pipe_pkg::WAIT : riscv_pipe_pkg::REQ;
                end else if (redirect) begin
                    state_d = riscv_pipe_pkg::DROP;
                end
            end
            riscv_pipe_pkg::DROP: begin
                if (imemRvalid) begin
                    state_d = granted ? riscv_pipe_pkg::WAIT : riscv_pipe_pkg::REQ;
                end
            end
            default: state_d = riscv_pipe_pkg::REQ;
        endcase
        if (redirect) begin
            fetch_pc_d = riscv_pipe_pkg::word_align(redirectPc);
        end
    end

    // State and address registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= riscv_pipe_pkg::REQ;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign push_entry = '{pc: req_addr_q, pc_add4: req_addr_q + XLEN'(4), inst: imemRdata};

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (push),
        .pop       (pop),
        .clear     (redirect),
        .push_data (push_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (head)
    );

    // Credit accounting must never let a word arrive with nowhere to go.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        push |-> (!fifo_full || pop));

    assign pc        = head.pc;
    assign pcAdd4    = head.pc_add4;
    assign inst      = head.inst;
    assign instValid = ~fifo_empty;
    assign flushOut  = redirect | (~instValid & ~stall);

endmodule
